// File: rtl/exception_controller.sv
// exception_controller
//   Multi-source exception/interrupt controller for the single-cycle LEGv8
//   core. Latches rising edges on N_IRQ device lines, arbitrates them against
//   the decoder's invalid-opcode flag, holds one request until the datapath
//   takes it, and blocks further requests until the handler returns (ERET).
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   irq_in       in   [N_IRQ] device level lines (synchronous to clk)
//   irq_mask     in   [N_IRQ] 1 = channel enabled
//   illegal_op   in   decoder: current instruction is undefined
//   eret         in   decoder: current instruction is ERET
//   exc_ack      in   datapath has taken the exception
//   exc          out  exception request to datapath
//   estatus      out  [ESTATUS_W] cause code, held through service
//   irq_ack      out  [N_IRQ] one-hot acknowledge to the granted device
//   pending      out  [N_IRQ] latched pending channels
//   in_service   out  handler running
//   irq_overrun  out  [N_IRQ] sticky: edge seen while already pending
//   double_fault out  sticky: illegal_op while in service

// Per-channel edge latch: pending/overrun state for one interrupt line.
module exception_controller_lane (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  input  logic i_ack,
  output logic o_pending,
  output logic o_overrun
);
  logic r_prev, r_pend, r_ovr;
  logic w_rise;

  assign w_rise    = i_irq & ~r_prev;
  assign o_pending = r_pend;
  assign o_overrun = r_ovr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_prev <= i_irq;
      // a new edge on the ack cycle keeps the channel pending
      r_pend <= w_rise | (r_pend & ~i_ack);
      if (w_rise && r_pend) r_ovr <= 1'b1;
    end
  end
endmodule

module exception_controller #(
  parameter int                   N_IRQ         = 4,
  parameter int                   ESTATUS_W     = 4,
  parameter logic [ESTATUS_W-1:0] INVOP_CODE    = 4'h2,
  parameter logic [ESTATUS_W-1:0] IRQ_CODE_BASE = 4'h8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     irq_in,
  input  logic [N_IRQ-1:0]     irq_mask,
  input  logic                 illegal_op,
  input  logic                 eret,
  input  logic                 exc_ack,
  output logic                 exc,
  output logic [ESTATUS_W-1:0] estatus,
  output logic [N_IRQ-1:0]     irq_ack,
  output logic [N_IRQ-1:0]     pending,
  output logic                 in_service,
  output logic [N_IRQ-1:0]     irq_overrun,
  output logic                 double_fault
);
  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]           r_state;
  logic                 r_gnt_irq;   // 0 = invalid-opcode grant
  logic [IDX_W-1:0]     r_gnt_idx;
  logic [ESTATUS_W-1:0] r_estatus;
  logic                 r_double_fault;

  logic [N_IRQ-1:0]     w_elig;
  logic [N_IRQ-1:0]     w_ack;
  logic [IDX_W-1:0]     w_sel;

  exception_controller_lane u_lane [N_IRQ-1:0] (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (irq_in),
    .i_ack     (w_ack),
    .o_pending (pending),
    .o_overrun (irq_overrun)
  );

  assign w_elig = pending & irq_mask;

  // lowest eligible index wins; scanning downward lets it overwrite last
  always_comb begin
    w_sel = '0;
    for (int k = N_IRQ-1; k >= 0; k--)
      if (w_elig[k]) w_sel = IDX_W'(k);
  end

  // combinational ack: only on the exc_ack cycle of an IRQ grant
  assign w_ack = (exc_ack && (r_state == S_REQ) && r_gnt_irq)
               ? (N_IRQ'(1) << r_gnt_idx) : '0;

  assign irq_ack      = w_ack;
  assign exc          = (r_state == S_REQ);
  assign in_service   = (r_state == S_SERVICE);
  assign estatus      = r_estatus;
  assign double_fault = r_double_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_gnt_irq      <= 1'b0;
      r_gnt_idx      <= '0;
      r_estatus      <= '0;
      r_double_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (illegal_op) begin
            r_state   <= S_REQ;
            r_gnt_irq <= 1'b0;
            r_estatus <= INVOP_CODE;
          end else if (|w_elig) begin
            r_state   <= S_REQ;
            r_gnt_irq <= 1'b1;
            r_gnt_idx <= w_sel;
            r_estatus <= IRQ_CODE_BASE + ESTATUS_W'(w_sel);
          end
        end
        // request is frozen: no re-arbitration, mask/illegal_op/eret ignored
        S_REQ: begin
          if (exc_ack) r_state <= S_SERVICE;
        end
        S_SERVICE: begin
          if (illegal_op) r_double_fault <= 1'b1;
          if (eret)       r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
